lcd_rx_mon: RTL
===============

LCD_RX_MON -- requirements
Module: lcd_rx_mon

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, meaning DE-high pixels expected per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines expected per frame.
REQ-003 SHALL have port lcd_clk_33m  input  1  pixel clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rgb_in  input  24  sampled panel pixel bus, R[23:16] G[15:8] B[7:0].
REQ-006 SHALL have port hsync_in  input  1  line sync, active-low.
REQ-007 SHALL have port vsync_in  input  1  frame sync, active-low.
REQ-008 SHALL have port de_in  input  1  data enable, active-high.
REQ-009 SHALL have port err_clr  input  1  single-cycle pulse clearing sticky errors.
REQ-010 SHALL have port rx_valid  output  1  recovered pixel strobe.
REQ-011 SHALL have port rx_data  output  24  recovered pixel value.
REQ-012 SHALL have port rx_x  output  11  recovered column, 0-based.
REQ-013 SHALL have port rx_y  output  11  recovered row, 0-based.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at end of each measured frame.
REQ-015 SHALL have port h_meas  output  11  DE-high length of last completed line.
REQ-016 SHALL have port v_meas  output  11  active-line count of last completed frame.
REQ-017 SHALL have port locked  output  1  timing matches parameters.
REQ-018 SHALL have ports err_h, err_v  output  1 each  sticky line/frame timing errors.
REQ-019 SHALL have port frame_sum  output  32  per-frame pixel checksum.

Function
REQ-020 SHALL register rgb_in/hsync_in/vsync_in/de_in once; all outputs registered; rx_* appear exactly 2 cycles after the sampled input cycle.
REQ-021 SHALL run FSM SEARCH -> WAIT_DE -> ACTIVE; SEARCH exits on vsync falling edge; WAIT_DE -> ACTIVE on first DE rising edge; ACTIVE -> WAIT_DE on next vsync falling edge.
REQ-022 SHALL keep rx_valid=0 in SEARCH; in WAIT_DE/ACTIVE rx_valid equals the delayed DE.
REQ-023 SHALL reset x to 0 on DE rising edge, increment per valid pixel, saturate at 2047.
REQ-024 SHALL increment y on each DE falling edge, reset to 0 on vsync falling edge, saturate at 2047.
REQ-025 SHALL on DE falling edge load h_meas with line length; length != H_ACTIVE sets err_h.
REQ-026 SHALL on vsync falling edge in ACTIVE load v_meas with line count, pulse frame_done; count != V_ACTIVE sets err_v.
REQ-027 SHALL set err_v if DE is high while vsync is low.
REQ-028 SHALL assert locked after 2 consecutive error-free frames; deassert in the same cycle any error event occurs; error count restarts.
REQ-029 SHALL clear err_h/err_v on err_clr; error event coincident with err_clr wins (flag stays set).
REQ-030 SHALL ignore hsync_in for counting; hsync only qualifies nothing (DE-based timing).

Reset
REQ-031 SHALL on rst_n low: FSM=SEARCH, all outputs 0, all counters 0, input registers 0 (syncs 1).
REQ-032 SHALL on reset mid-frame discard the partial frame and require a fresh vsync falling edge before rx_valid.

Configuration
REQ-033 SHALL with LCD_RX_CHECKSUM_EN defined accumulate a 32-bit wrapping sum of {8'h0,rx_data} over valid pixels, latch into frame_sum with frame_done, clear accumulator at frame start.
REQ-034 SHALL without LCD_RX_CHECKSUM_EN drive frame_sum constant 0 and instantiate no accumulator.

Verification
REQ-035 Nominal 800x480 frames, rgb=24'h000001 -> frame_done each frame, h_meas=800, v_meas=480, locked=1 after 2nd frame_done, frame_sum=384000 (macro on).
REQ-036 One line with 799 DE cycles in frame 3 -> err_h=1 at that DE fall, h_meas=799, locked=0 same cycle, relocks after 2 clean frames.
REQ-037 Frame with 479 lines -> v_meas=479, err_v=1, locked=0; err_clr pulse -> err_h=err_v=0.
REQ-038 DE asserted before first vsync falling edge -> rx_valid stays 0, no counters change.
REQ-039 rst_n low at pixel (400,200) -> all outputs 0 asynchronously; after release, no rx_valid until next vsync falling edge.
REQ-040 First pixel after vsync fall, rgb=24'hABCDEF at DE rise cycle N -> rx_valid=1, rx_x=0, rx_y=0, rx_data=24'hABCDEF at cycle N+2.

Source files
------------

// File: rtl/lcd_rx_mon.sv
// Parallel RGB LCD receive monitor: recovers pixel coordinates from DE/VSYNC and checks timing.
// Optional per-frame checksum is built only when LCD_RX_CHECKSUM_EN is defined.
module lcd_rx_mon #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        lcd_clk_33m,
  input  logic        rst_n,
  input  logic [23:0] rgb_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  input  logic        err_clr,
  output logic        rx_valid,
  output logic [23:0] rx_data,
  output logic [10:0] rx_x,
  output logic [10:0] rx_y,
  output logic        frame_done,
  output logic [10:0] h_meas,
  output logic [10:0] v_meas,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [31:0] frame_sum
);

  localparam logic [10:0] HActive = 11'(H_ACTIVE);
  localparam logic [10:0] VActive = 11'(V_ACTIVE);

  typedef enum logic [1:0] {StSearch, StWaitDe, StActive} state_e;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7ff) ? v : v + 11'd1;
  endfunction

  // Input sampling stage plus one cycle of history for edge detection
  logic [23:0] rgb_q;
  logic        hs_q, vs_q, de_q, vs_prev_q, de_prev_q;

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      de_q      <= 1'b0;
      vs_prev_q <= 1'b1;
      de_prev_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_in;
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
      de_q      <= de_in;
      vs_prev_q <= vs_q;
      de_prev_q <= de_q;
    end
  end

  // Timing is derived from DE alone; hsync is sampled but deliberately unused.
  logic unused_hs;
  assign unused_hs = hs_q;

  state_e state_q, state_d;
  logic   vs_fall, de_rise, de_fall, tracking, pix_valid, frame_end, line_end;
  logic   h_evt, v_evt, evt;

  assign vs_fall   = vs_prev_q & ~vs_q;
  assign de_rise   = de_q & ~de_prev_q;
  assign de_fall   = ~de_q & de_prev_q;
  assign tracking  = (state_q != StSearch);
  assign pix_valid = tracking & de_q;
  assign frame_end = vs_fall & (state_q == StActive);
  assign line_end  = tracking & de_fall;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSearch: if (vs_fall) state_d = StWaitDe;
      StWaitDe: if (de_rise) state_d = StActive;
      StActive: if (vs_fall) state_d = StWaitDe;
      default:  state_d = StSearch;
    endcase
  end

  logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, x_cur;
  logic [1:0]  ok_cnt_q, ok_cnt_d;
  logic        frame_err_q, frame_err_d, locked_d;

  assign x_cur = de_rise ? 11'd0 : x_cnt_q;
  assign h_evt = line_end & (x_cnt_q != HActive);
  // DE high during vsync low is a frame-level fault as well as a line-count mismatch
  assign v_evt = (frame_end & (y_cnt_q != VActive)) | (tracking & de_q & ~vs_q);
  assign evt   = h_evt | v_evt;

  always_comb begin
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    ok_cnt_d    = ok_cnt_q;
    locked_d    = locked;
    frame_err_d = frame_err_q | evt;
    if (pix_valid) x_cnt_d = sat_inc(x_cur);
    if (vs_fall) begin
      y_cnt_d     = 11'd0;
      frame_err_d = 1'b0;
    end else if (line_end) begin
      y_cnt_d = sat_inc(y_cnt_q);
    end
    if (evt) begin
      ok_cnt_d = 2'd0;
      locked_d = 1'b0;
    end else if (frame_end) begin
      if (frame_err_q) begin
        ok_cnt_d = 2'd0;
      end else if (ok_cnt_q != 2'd2) begin
        ok_cnt_d = ok_cnt_q + 2'd1;
      end
      locked_d = ~frame_err_q & (ok_cnt_q != 2'd0);
    end
  end

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSearch;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      ok_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_x        <= '0;
      rx_y        <= '0;
      frame_done  <= 1'b0;
      h_meas      <= '0;
      v_meas      <= '0;
      locked      <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      ok_cnt_q    <= ok_cnt_d;
      frame_err_q <= frame_err_d;
      rx_valid    <= pix_valid;
      if (pix_valid) begin
        rx_data <= rgb_q;
        rx_x    <= x_cur;
        rx_y    <= y_cnt_q;
      end
      frame_done <= frame_end;
      if (line_end)  h_meas <= x_cnt_q;
      if (frame_end) v_meas <= y_cnt_q;
      locked <= locked_d;
      // A new error in the clearing cycle keeps the flag set
      err_h  <= h_evt | (err_h & ~err_clr);
      err_v  <= v_evt | (err_v & ~err_clr);
    end
  end

`ifdef LCD_RX_CHECKSUM_EN
  logic [31:0] acc_q, acc_d, acc_base, sum_q;

  assign acc_base = vs_fall ? 32'd0 : acc_q;
  assign acc_d    = pix_valid ? acc_base + {8'h0, rgb_q} : acc_base;

  always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (frame_end) sum_q <= acc_q;
    end
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = 32'd0;
`endif

endmodule
